// File: rtl/regbank_flat.sv
// -----------------------------------------------------------------------------
// regbank_flat
//
// General-purpose register bank for the MIPS datapath. It holds 2**SEL
// registers of BUS_WIDTH bits each and has two write ports:
//   - an ALU write-back port with no handshake, which always wins;
//   - a handshaked load write-back port (valid/ready), which stalls whenever
//     the ALU port writes the same nonzero register in the same cycle.
// A pending-load scoreboard keeps one busy bit per register and raises a
// sticky error flag on protocol violations.
//
// Every register is presented on one flattened bus for the decode-stage
// read multiplexers: register k occupies bits [k*BUS_WIDTH +: BUS_WIDTH].
// Register 0 always reads zero, ignores writes and is never marked busy.
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_rst            synchronous active-high reset
//   i_wb_en          ALU write-back enable
//   i_wb_addr        ALU write-back destination        [SEL]
//   i_wb_data        ALU write-back value              [BUS_WIDTH]
//   i_ld_issue       a load to i_ld_addr is issued this cycle
//   i_ld_addr        destination of the issued load    [SEL]
//   i_ld_wb_valid    load write-back data is present
//   o_ld_wb_ready    load write-back accepted this cycle (combinational)
//   i_ld_wb_addr     load write-back destination       [SEL]
//   i_ld_wb_data     load write-back value             [BUS_WIDTH]
//   o_regs_flat      all registers, flattened          [BUS_WIDTH*2**SEL]
//   o_busy_flat      per-register outstanding-load bit [2**SEL]
//   o_err            sticky scoreboard protocol error
// -----------------------------------------------------------------------------
module regbank_flat #(
    parameter int BUS_WIDTH = 32,
    parameter int SEL       = 5
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_wb_en,
    input  logic [SEL-1:0]                   i_wb_addr,
    input  logic [BUS_WIDTH-1:0]             i_wb_data,
    input  logic                             i_ld_issue,
    input  logic [SEL-1:0]                   i_ld_addr,
    input  logic                             i_ld_wb_valid,
    output logic                             o_ld_wb_ready,
    input  logic [SEL-1:0]                   i_ld_wb_addr,
    input  logic [BUS_WIDTH-1:0]             i_ld_wb_data,
    output logic [BUS_WIDTH*(2**SEL)-1:0]    o_regs_flat,
    output logic [(2**SEL)-1:0]              o_busy_flat,
    output logic                             o_err
);

    localparam int NREG = 2 ** SEL;

    // Packed so that element k lands at bits [k*BUS_WIDTH +: BUS_WIDTH]
    // when the whole array is driven onto the flat output.
    logic [NREG-1:0][BUS_WIDTH-1:0] r_regs;
    logic [NREG-1:0]                r_busy;
    logic                           r_err;

    logic                           w_ld_ready;
    logic                           w_ld_accept;
    logic [NREG-1:0]                w_wb_sel;
    logic [NREG-1:0]                w_ld_sel;
    logic [NREG-1:0]                w_iss_sel;
    logic                           w_iss_err;
    logic                           w_wb_err;

    // The load port only stalls on a same-register collision with the ALU
    // port; a collision on register 0 is harmless because both writes are
    // dropped anyway. Deliberately independent of i_ld_wb_valid.
    assign w_ld_ready  = !i_rst &&
                         !(i_wb_en && (i_wb_addr == i_ld_wb_addr) && (i_wb_addr != '0));
    assign w_ld_accept = i_ld_wb_valid && w_ld_ready;

    // One-hot target decodes; bit 0 is masked so register 0 stays zero and
    // never becomes busy.
    always_comb begin
        w_wb_sel  = '0;
        w_ld_sel  = '0;
        w_iss_sel = '0;
        if (i_wb_en) begin
            w_wb_sel[i_wb_addr] = 1'b1;
        end
        if (w_ld_accept) begin
            w_ld_sel[i_ld_wb_addr] = 1'b1;
        end
        if (i_ld_issue) begin
            w_iss_sel[i_ld_addr] = 1'b1;
        end
        w_wb_sel[0]  = 1'b0;
        w_ld_sel[0]  = 1'b0;
        w_iss_sel[0] = 1'b0;
    end

    // Issuing to a register that already has a load in flight is only legal
    // when that same load completes in this cycle. busy[0] is never set, so
    // an issue to register 0 cannot flag.
    assign w_iss_err = i_ld_issue && r_busy[i_ld_addr] && !w_ld_sel[i_ld_addr];

    // A completion for a register nobody was waiting on.
    assign w_wb_err  = w_ld_accept && (i_ld_wb_addr != '0) && !r_busy[i_ld_wb_addr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_regs <= '0;
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_regs[0] <= '0;
            // The ALU and load ports never hit the same register in one cycle
            // (the load port stalls), so the order here only documents intent.
            for (int k = 1; k < NREG; k++) begin
                if (w_wb_sel[k]) begin
                    r_regs[k] <= i_wb_data;
                end else if (w_ld_sel[k]) begin
                    r_regs[k] <= i_ld_wb_data;
                end
            end
            // Clear first, then set: an issue and a completion to the same
            // register in one cycle leave it busy.
            r_busy <= (r_busy & ~w_ld_sel) | w_iss_sel;
            if (w_iss_err || w_wb_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_ld_wb_ready = w_ld_ready;
    assign o_regs_flat   = r_regs;
    assign o_busy_flat   = r_busy;
    assign o_err         = r_err;

endmodule

// File: tb/tb_regbank_flat.sv
module tb_regbank_flat;

    localparam int BW   = 32;
    localparam int SEL  = 5;
    localparam int NREG = 32;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_wb_en;
    logic [SEL-1:0]      i_wb_addr;
    logic [BW-1:0]       i_wb_data;
    logic                i_ld_issue;
    logic [SEL-1:0]      i_ld_addr;
    logic                i_ld_wb_valid;
    logic                o_ld_wb_ready;
    logic [SEL-1:0]      i_ld_wb_addr;
    logic [BW-1:0]       i_ld_wb_data;
    logic [BW*NREG-1:0]  o_regs_flat;
    logic [NREG-1:0]     o_busy_flat;
    logic                o_err;

    regbank_flat #(.BUS_WIDTH(BW), .SEL(SEL)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_wb_en       (i_wb_en),
        .i_wb_addr     (i_wb_addr),
        .i_wb_data     (i_wb_data),
        .i_ld_issue    (i_ld_issue),
        .i_ld_addr     (i_ld_addr),
        .i_ld_wb_valid (i_ld_wb_valid),
        .o_ld_wb_ready (o_ld_wb_ready),
        .i_ld_wb_addr  (i_ld_wb_addr),
        .i_ld_wb_data  (i_ld_wb_data),
        .o_regs_flat   (o_regs_flat),
        .o_busy_flat   (o_busy_flat),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain arrays updated from the behavioural rules.
    logic [BW-1:0] m_reg  [NREG];
    bit            m_busy [NREG];
    bit            m_err;
    bit            last_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] dut_reg(input int k);
        return o_regs_flat[k*BW +: BW];
    endfunction

    task automatic compare_all(input string where);
        for (int k = 0; k < NREG; k++) begin
            check($sformatf("%s_reg%0d", where, k), 64'(dut_reg(k)), 64'(m_reg[k]));
            check($sformatf("%s_busy%0d", where, k), 64'(o_busy_flat[k]), 64'(m_busy[k]));
        end
        check($sformatf("%s_err", where), 64'(o_err), 64'(m_err));
    endtask

    // Called with inputs already driven, away from the edge. Checks ready,
    // advances the model, takes one edge and compares everything.
    task automatic cycle(input string where);
        bit exp_ready;
        bit acc;
        #2;
        exp_ready = !i_rst && !(i_wb_en && i_wb_addr == i_ld_wb_addr && i_wb_addr != 0);
        check({where, "_ready"}, 64'(o_ld_wb_ready), 64'(exp_ready));
        acc = i_ld_wb_valid && exp_ready;
        if (i_rst) begin
            for (int k = 0; k < NREG; k++) begin
                m_reg[k]  = '0;
                m_busy[k] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            if (i_ld_issue && i_ld_addr != 0 && m_busy[i_ld_addr] &&
                !(acc && i_ld_wb_addr == i_ld_addr))
                m_err = 1'b1;
            if (acc && i_ld_wb_addr != 0 && !m_busy[i_ld_wb_addr])
                m_err = 1'b1;
            if (i_wb_en && i_wb_addr != 0) m_reg[i_wb_addr] = i_wb_data;
            if (acc && i_ld_wb_addr != 0) begin
                m_reg[i_ld_wb_addr]  = i_ld_wb_data;
                m_busy[i_ld_wb_addr] = 1'b0;
            end
            if (i_ld_issue && i_ld_addr != 0) m_busy[i_ld_addr] = 1'b1;
        end
        last_acc = acc;
        @(posedge i_clk);
        #1;
        compare_all(where);
    endtask

    task automatic idle_inputs();
        i_rst = 0; i_wb_en = 0; i_wb_addr = 0; i_wb_data = 0;
        i_ld_issue = 0; i_ld_addr = 0;
        i_ld_wb_valid = 0; i_ld_wb_addr = 0; i_ld_wb_data = 0;
    endtask

    initial begin
        bit hold;
        int nb;
        int pick [$];
        idle_inputs();
        for (int k = 0; k < NREG; k++) begin m_reg[k] = 'x; m_busy[k] = 0; end
        m_err = 0;
        @(negedge i_clk);

        // Reset, then a basic ALU write.
        i_rst = 1;
        cycle("rst");
        check("rst_err", 64'(o_err), 64'(0));
        i_rst = 0;
        i_wb_en = 1; i_wb_addr = 5; i_wb_data = 32'hDEADBEEF;
        cycle("t1");
        check("t1_reg5_const", 64'(dut_reg(5)), 64'h0000_0000_DEAD_BEEF);
        check("t1_reg4_const", 64'(dut_reg(4)), 64'h0);

        // Register 0 immunity.
        i_wb_addr = 0; i_wb_data = 32'hFFFFFFFF;
        cycle("t2a");
        i_wb_en = 0; i_ld_issue = 1; i_ld_addr = 0;
        cycle("t2b");
        check("t2_reg0_const", 64'(dut_reg(0)), 64'h0);
        check("t2_busy0_const", 64'(o_busy_flat[0]), 64'h0);
        check("t2_err_const", 64'(o_err), 64'h0);

        // Port conflict on register 7.
        i_ld_addr = 7;
        cycle("t3a");
        i_ld_issue = 0;
        i_ld_wb_valid = 1; i_ld_wb_addr = 7; i_ld_wb_data = 32'h11;
        i_wb_en = 1; i_wb_addr = 7; i_wb_data = 32'h22;
        #1;
        check("t3_ready_low", 64'(o_ld_wb_ready), 64'h0);
        cycle("t3b");
        check("t3_reg7_alu", 64'(dut_reg(7)), 64'h22);
        i_wb_en = 0;
        #1;
        check("t3_ready_high", 64'(o_ld_wb_ready), 64'h1);
        cycle("t3c");
        i_ld_wb_valid = 0;
        check("t3_reg7_load", 64'(dut_reg(7)), 64'h11);
        check("t3_busy7", 64'(o_busy_flat[7]), 64'h0);

        // Simultaneous issue and completion on register 9.
        i_ld_issue = 1; i_ld_addr = 9;
        cycle("t4a");
        i_ld_wb_valid = 1; i_ld_wb_addr = 9; i_ld_wb_data = 32'h33;
        cycle("t4b");
        i_ld_issue = 0; i_ld_wb_valid = 0;
        check("t4_reg9", 64'(dut_reg(9)), 64'h33);
        check("t4_busy9", 64'(o_busy_flat[9]), 64'h1);
        check("t4_err", 64'(o_err), 64'h0);

        // Completion to a non-busy register sets the sticky error.
        i_ld_wb_valid = 1; i_ld_wb_addr = 4; i_ld_wb_data = 32'h44;
        cycle("t5a");
        i_ld_wb_valid = 0;
        check("t5_err_set", 64'(o_err), 64'h1);
        check("t5_reg4", 64'(dut_reg(4)), 64'h44);
        for (int i = 0; i < 3; i++) begin
            i_wb_en = 1; i_wb_addr = 5'(10 + i); i_wb_data = $urandom;
            cycle("t5b");
        end
        i_wb_en = 0;
        check("t5_err_sticky", 64'(o_err), 64'h1);
        i_rst = 1;
        cycle("t5c");
        i_rst = 0;
        check("t5_err_cleared", 64'(o_err), 64'h0);

        // Reset while a load write-back is pending.
        i_ld_issue = 1; i_ld_addr = 3;
        cycle("t6a");
        i_ld_issue = 0;
        i_ld_wb_valid = 1; i_ld_wb_addr = 3; i_ld_wb_data = 32'h55;
        i_rst = 1;
        #1;
        check("t6_ready_rst", 64'(o_ld_wb_ready), 64'h0);
        cycle("t6b");
        check("t6_reg3", 64'(dut_reg(3)), 64'h0);
        check("t6_busy3", 64'(o_busy_flat[3]), 64'h0);
        idle_inputs();

        // Randomized traffic; the load source holds a stalled transfer.
        hold = 0;
        for (int n = 0; n < 600; n++) begin
            i_rst = ($urandom_range(0, 59) == 0);
            if (!hold) begin
                i_ld_wb_valid = ($urandom_range(0, 2) != 0);
                pick.delete();
                for (int k = 1; k < NREG; k++) if (m_busy[k]) pick.push_back(k);
                nb = pick.size();
                if (nb > 0 && $urandom_range(0, 7) != 0)
                    i_ld_wb_addr = 5'(pick[$urandom_range(0, nb - 1)]);
                else
                    i_ld_wb_addr = 5'($urandom_range(0, NREG - 1));
                i_ld_wb_data = $urandom;
            end
            i_wb_en   = $urandom_range(0, 1);
            i_wb_addr = ($urandom_range(0, 3) == 0) ? i_ld_wb_addr
                                                    : 5'($urandom_range(0, NREG - 1));
            i_wb_data = $urandom;
            i_ld_issue = ($urandom_range(0, 2) == 0);
            i_ld_addr  = 5'($urandom_range(0, NREG - 1));
            cycle("rnd");
            hold = i_ld_wb_valid && !last_acc;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regbank_flat.md
# regbank_flat

General-purpose register bank for the MIPS datapath: 2**SEL registers of BUS_WIDTH bits with one ALU write-back port, one handshaked load write-back port, and a pending-load scoreboard. All register contents are presented as one flattened bus, so that read-select multiplexers index it directly: register k occupies bits [k*BUS_WIDTH +: BUS_WIDTH]. The block sits directly upstream of the read-port multiplexers in the decode stage. It also exports a per-register busy vector for the hazard unit.

## Interface
- BUS_WIDTH, default 32: width of each register.
- SEL, default 5: register-address width; the bank holds 2**SEL registers.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_en  input  1  ALU write-back enable.
- wb_addr  input  SEL  ALU write-back destination.
- wb_data  input  BUS_WIDTH  ALU write-back value.
- ld_issue  input  1  a load targeting ld_addr is issued this cycle.
- ld_addr  input  SEL  destination register of the issued load.
- ld_wb_valid  input  1  load write-back data is present.
- ld_wb_ready  output  1  the load write-back is accepted this cycle (combinational).
- ld_wb_addr  input  SEL  load write-back destination.
- ld_wb_data  input  BUS_WIDTH  load write-back value.
- regs_flat  output  BUS_WIDTH*2**SEL  all registers, flattened, taken directly from the state flops.
- busy_flat  output  2**SEL  bit k set while a load to register k is outstanding.
- err  output  1  sticky scoreboard protocol error flag.

## Operation
- **Register 0:**
  - Always reads zero.
  - Writes to it from either port are discarded.
  - Its busy bit is never set.
- **ALU port:** when wb_en=1 and wb_addr!=0, register[wb_addr] takes wb_data at the edge. There is no handshake; the port always wins.
- **Load port:**
  - ld_wb_ready = !rst && !(wb_en && wb_addr==ld_wb_addr && wb_addr!=0).
  - An accepted transfer is valid && ready.
  - An accepted transfer writes ld_wb_data to register[ld_wb_addr] (ignored for address 0) and clears busy[ld_wb_addr].
  - When ready=0, the source holds valid, addr and data stable until accepted.
- **Different addresses:** ALU and load writes to different registers in the same cycle both take effect.
- **Scoreboard:**
  - ld_issue with ld_addr!=0 sets busy[ld_addr].
  - If the same register is both issued and cleared in one cycle, the set wins: the busy bit ends at 1.
  - An ALU write to a busy register updates the data and leaves the busy bit unchanged.
- **err, set (sticky) when:**
  - ld_issue targets a register that is already busy and is not being cleared that cycle; or
  - an accepted load write-back targets a nonzero register whose busy bit is 0.
  - In either case the data and busy updates still proceed as described above.
  - Only rst clears err.
- **No internal bypass:** a value written at edge N appears on regs_flat after edge N. Same-cycle forwarding is the hazard unit's job.

## Timing
- **Reset (rst=1 at an edge):** all registers 0, busy_flat=0, err=0. While rst is high, ld_wb_ready=0 and all write and issue inputs are ignored.
- **Write latency:** one edge, on either port. regs_flat and busy_flat are registered outputs.
- **ld_wb_ready:** purely combinational from rst, wb_en, wb_addr and ld_wb_addr. It does not depend on ld_wb_valid.
- **Reset mid-transfer:** an in-flight load write-back is dropped, and all busy bits clear at that edge. The load source must re-present the transfer after reset.
- **Wrap/limits:** addresses are full-range SEL bits and all 2**SEL indices are legal. No counters exist, so there are no overflow cases.

## Test plan
- **Reset then basic write:** rst one cycle; wb_en=1, wb_addr=5, wb_data=0xDEADBEEF -> next cycle regs_flat[5*32 +: 32]=0xDEADBEEF, all other registers 0, err=0.
- **Register 0 immunity:** wb to addr 0 with 0xFFFFFFFF; then ld_issue with ld_addr=0 -> register 0 stays 0, busy_flat[0]=0, err=0.
- **Port conflict:**
  - Setup: ld_issue addr 7; next cycle ld_wb_valid=1 with addr 7, data 0x11 while wb_en=1 with addr 7, data 0x22.
  - Required: ready=0 that cycle and reg7=0x22 next cycle.
  - Following cycle, with wb_en=0: ready=1, then reg7=0x11 and busy[7]=0.
- **Simultaneous issue and complete:** busy[9]=1; in one cycle ld_issue addr 9 plus accepted write-back addr 9 data 0x33 -> reg9=0x33, busy[9]=1, err=0.
- **Error flag:**
  - Accepted write-back to non-busy register 4 -> err=1, reg4 written.
  - err stays 1 across later clean traffic and clears only after rst.
- **Reset mid-operation:** busy[3]=1 and ld_wb_valid=1 for addr 3 at the edge where rst=1 -> reg3=0, busy[3]=0, ld_wb_ready=0 during rst.
